mem_access_stage: RTL and testbench

Memory-access pipeline stage that consumes the execute stage's registered outputs (instruction, ALU result, store data, control byte) and performs RISC-V loads and stores against a data-memory port with a request/grant/response handshake. It generates byte enables and lane-shifted write data, extracts and sign- or zero-extends load data, and registers the result into the MEM/WB boundary. While a memory transaction is outstanding it stalls the upstream pipeline.

---
 rtl/mem_access_stage_pkg.sv | 34 +++
 rtl/mem_access_stage_load_align.sv | 38 +++
 rtl/mem_access_stage.sv | 166 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared constants, state encoding and access-legality helper for the memory-access stage.
package mem_access_stage_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  // Width code must exist for the direction and the address must be naturally aligned.
  function automatic logic access_ok(input logic is_store, input logic [2:0] f3,
                                     input logic [1:0] ofs);
    logic ok;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~ofs[0];
      F3_W:    ok = (ofs == 2'b00);
      F3_BU:   ok = ~is_store;
      F3_HU:   ok = ~is_store & ~ofs[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Load data extraction: lane shift of the returned word plus sign/zero extension by funct3.
module mem_access_stage_load_align
  import mem_access_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  ofs,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  function automatic logic [31:0] sext8(input logic signed [7:0] v);
    logic signed [31:0] w;
    w = 32'(v);
    return w;
  endfunction

  function automatic logic [31:0] sext16(input logic signed [15:0] v);
    logic signed [31:0] w;
    w = 32'(v);
    return w;
  endfunction

  assign shifted = rdata >> {ofs, 3'b000};

  always_comb begin
    data = shifted;
    case (funct3)
      F3_B:    data = sext8(shifted[7:0]);
      F3_BU:   data = {24'h0, shifted[7:0]};
      F3_H:    data = sext16(shifted[15:0]);
      F3_HU:   data = {16'h0, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// RISC-V memory-access stage: issues loads/stores on a req/gnt/rvalid port, stalls EX
// while busy, and registers results into the MEM/WB boundary.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk1,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] ex_ir,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_store_data,
  input  logic [7:0]  ex_ctrl,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_ir,
  output logic [31:0] wb_result,
  output logic [31:0] wb_load_data,
  output logic [7:0]  wb_ctrl,
  output logic        wb_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;

  logic              vld_p0, is_ld_p0, is_st_p0, is_mem_p0, ok_p0;
  logic [2:0]        f3_p0;
  logic [3:0]        be_p0;
  logic [31:0]       wdata_p0;
  logic              start, fault, pass, busy, st_done, ld_done, tmo;

  logic [2:0]        f3_p1;
  logic [1:0]        ofs_p1;
  logic [31:0]       ir_p1, res_p1;
  logic [7:0]        ctrl_p1;
  logic [31:0]       ld_data;

  // ---- stage p0: decode of the held EX outputs ----
  assign vld_p0    = ex_valid & (state == IDLE);
  assign f3_p0     = ex_ir[14:12];
  assign is_ld_p0  = (ex_ir[6:0] == OP_LOAD);
  assign is_st_p0  = (ex_ir[6:0] == OP_STORE);
  assign is_mem_p0 = is_ld_p0 | is_st_p0;
  assign ok_p0     = access_ok(is_st_p0, f3_p0, ex_result[1:0]);

  assign start = vld_p0 & is_mem_p0 & ok_p0;
  assign fault = vld_p0 & is_mem_p0 & ~ok_p0;
  assign pass  = vld_p0 & ~is_mem_p0;

  always_comb begin
    be_p0 = 4'b1111;
    case (f3_p0)
      F3_B, F3_BU: be_p0 = 4'b0001 << ex_result[1:0];
      F3_H, F3_HU: be_p0 = 4'b0011 << ex_result[1:0];
      default:     be_p0 = 4'b1111;
    endcase
  end

  assign wdata_p0 = ex_store_data << {ex_result[1:0], 3'b000};

  assign busy    = (state == REQ) | (state == WAIT);
  assign st_done = (state == REQ) & dmem_gnt & dmem_we;
  assign ld_done = (state == WAIT) & dmem_rvalid;
  // Completion in the same cycle wins over the timeout.
  assign tmo     = busy & (cnt == CNT_W'(TIMEOUT - 1)) & ~st_done & ~ld_done;

  assign stall    = start | (busy & ~(st_done | ld_done | tmo));
  assign dmem_req = (state == REQ);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = REQ;
      REQ: begin
        if (st_done | tmo)  state_nx = IDLE;
        else if (dmem_gnt)  state_nx = WAIT;
      end
      WAIT: if (ld_done | tmo) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (start)     cnt <= '0;
      else if (busy) cnt <= cnt + CNT_W'(1);
    end
  end

  // ---- stage p1: access latched on leaving IDLE, held until completion ----
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      f3_p1      <= '0;
      ofs_p1     <= '0;
      ir_p1      <= '0;
      res_p1     <= '0;
      ctrl_p1    <= '0;
    end else if (start) begin
      dmem_we    <= is_st_p0;
      dmem_addr  <= {ex_result[31:2], 2'b00};
      dmem_be    <= be_p0;
      dmem_wdata <= is_st_p0 ? wdata_p0 : 32'h0;
      f3_p1      <= f3_p0;
      ofs_p1     <= ex_result[1:0];
      ir_p1      <= ex_ir;
      res_p1     <= ex_result;
      ctrl_p1    <= ex_ctrl;
    end
  end

  mem_access_stage_load_align u_load_align (
    .rdata  (dmem_rdata),
    .ofs    (ofs_p1),
    .funct3 (f3_p1),
    .data   (ld_data)
  );

  // ---- stage p2: MEM/WB boundary ----
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid     <= 1'b0;
      wb_ir        <= '0;
      wb_result    <= '0;
      wb_load_data <= '0;
      wb_ctrl      <= '0;
      wb_err       <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      if (pass | fault) begin
        wb_valid     <= 1'b1;
        wb_ir        <= ex_ir;
        wb_result    <= ex_result;
        wb_ctrl      <= ex_ctrl;
        wb_load_data <= '0;
        wb_err       <= fault;
      end else if (st_done | ld_done | tmo) begin
        wb_valid     <= 1'b1;
        wb_ir        <= ir_p1;
        wb_result    <= res_p1;
        wb_ctrl      <= ctrl_p1;
        wb_load_data <= ld_done ? ld_data : 32'h0;
        wb_err       <= tmo;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: table-driven single-cycle, load and store vectors
// plus hand-written multi-cycle sequences (stall/handshake, timeout, reset mid-access).
module tb_mem_access_stage;

  localparam logic [6:0] OPC_ADD = 7'b0110011;
  localparam logic [6:0] OPC_LD  = 7'b0000011;
  localparam logic [6:0] OPC_ST  = 7'b0100011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;

  logic        clk1 = 1'b0;
  logic        rst_n = 1'b1;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_ir = '0, ex_result = '0, ex_store_data = '0;
  logic [7:0]  ex_ctrl = '0;
  logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        stall, dmem_req, dmem_we, wb_valid, wb_err;
  logic [31:0] dmem_addr, dmem_wdata, wb_ir, wb_result, wb_load_data;
  logic [3:0]  dmem_be;
  logic [7:0]  wb_ctrl;

  int checks = 0;
  int failures = 0;

  always #5 clk1 = ~clk1;

  mem_access_stage #(.TIMEOUT(16)) dut (
    .clk1(clk1), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ir(ex_ir),
    .ex_result(ex_result), .ex_store_data(ex_store_data), .ex_ctrl(ex_ctrl),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
    .wb_ir(wb_ir), .wb_result(wb_result), .wb_load_data(wb_load_data),
    .wb_ctrl(wb_ctrl), .wb_err(wb_err)
  );

  function automatic logic [31:0] mk_ir(input logic [2:0] f3, input logic [6:0] op);
    return {12'h0A5, 5'd2, f3, 5'd3, op};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk1);
    @(negedge clk1);
  endtask

  task automatic drive(input logic v, input logic [31:0] ir, input logic [31:0] res,
                       input logic [31:0] sd, input logic [7:0] c);
    ex_valid = v; ex_ir = ir; ex_result = res; ex_store_data = sd; ex_ctrl = c;
  endtask

  typedef struct {
    logic v; logic [31:0] ir; logic [31:0] res; logic [7:0] ctrl;
    logic e_vld; logic e_err; logic [31:0] e_ir; logic [31:0] e_res; logic [7:0] e_ctrl;
  } vec_t;

  typedef struct {
    logic [2:0] f3; logic [31:0] addr; logic [31:0] rdata;
    logic [3:0] e_be; logic [31:0] e_data;
  } ld_t;

  typedef struct {
    logic [2:0] f3; logic [31:0] addr; logic [31:0] sdata;
    logic [3:0] e_be; logic [31:0] e_wdata;
  } st_t;

  vec_t vt[11];
  ld_t  lt[8];
  st_t  stv[4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall_cnt, pulses, n;
    logic done;

    // Single-cycle: pass-through, faults, and idle (ex_valid=0) holds.
    vt[0]  = '{1'b1, mk_ir(3'd0, OPC_ADD), 32'h0000_1234, 8'h5A, 1'b1, 1'b0, mk_ir(3'd0, OPC_ADD), 32'h0000_1234, 8'h5A};
    vt[1]  = '{1'b1, mk_ir(3'd2, OPC_LD),  32'h0000_0006, 8'h11, 1'b1, 1'b1, mk_ir(3'd2, OPC_LD),  32'h0000_0006, 8'h11};
    vt[2]  = '{1'b0, mk_ir(3'd0, OPC_LD),  32'h0000_0100, 8'h22, 1'b0, 1'b1, mk_ir(3'd2, OPC_LD),  32'h0000_0006, 8'h11};
    vt[3]  = '{1'b1, mk_ir(3'd4, OPC_ST),  32'h0000_0000, 8'h33, 1'b1, 1'b1, mk_ir(3'd4, OPC_ST),  32'h0000_0000, 8'h33};
    vt[4]  = '{1'b1, mk_ir(3'd1, OPC_LD),  32'h0000_0001, 8'h44, 1'b1, 1'b1, mk_ir(3'd1, OPC_LD),  32'h0000_0001, 8'h44};
    vt[5]  = '{1'b1, mk_ir(3'd1, OPC_ST),  32'h0000_0003, 8'h55, 1'b1, 1'b1, mk_ir(3'd1, OPC_ST),  32'h0000_0003, 8'h55};
    vt[6]  = '{1'b1, mk_ir(3'd3, OPC_LD),  32'h0000_0000, 8'h66, 1'b1, 1'b1, mk_ir(3'd3, OPC_LD),  32'h0000_0000, 8'h66};
    vt[7]  = '{1'b1, mk_ir(3'd0, OPC_LUI), 32'hABCD_0000, 8'h77, 1'b1, 1'b0, mk_ir(3'd0, OPC_LUI), 32'hABCD_0000, 8'h77};
    vt[8]  = '{1'b0, mk_ir(3'd0, OPC_ST),  32'h0000_0008, 8'h88, 1'b0, 1'b0, mk_ir(3'd0, OPC_LUI), 32'hABCD_0000, 8'h77};
    vt[9]  = '{1'b1, mk_ir(3'd5, OPC_ST),  32'h0000_0000, 8'h99, 1'b1, 1'b1, mk_ir(3'd5, OPC_ST),  32'h0000_0000, 8'h99};
    vt[10] = '{1'b1, mk_ir(3'd6, OPC_LD),  32'h0000_0004, 8'hAA, 1'b1, 1'b1, mk_ir(3'd6, OPC_LD),  32'h0000_0004, 8'hAA};

    // Loads: rdata bytes [31:24]=80 [23:16]=FF [15:8]=12 [7:0]=34.
    lt[0] = '{3'd0, 32'h0000_0103, 32'h80FF_1234, 4'b1000, 32'hFFFF_FF80};
    lt[1] = '{3'd4, 32'h0000_0002, 32'h80FF_1234, 4'b0100, 32'h0000_00FF};
    lt[2] = '{3'd0, 32'h0000_0002, 32'h80FF_1234, 4'b0100, 32'hFFFF_FFFF};
    lt[3] = '{3'd1, 32'h0000_0002, 32'h80FF_1234, 4'b1100, 32'hFFFF_80FF};
    lt[4] = '{3'd5, 32'h0000_0002, 32'h80FF_1234, 4'b1100, 32'h0000_80FF};
    lt[5] = '{3'd1, 32'h0000_0040, 32'h80FF_1234, 4'b0011, 32'h0000_1234};
    lt[6] = '{3'd2, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF};
    lt[7] = '{3'd0, 32'h0000_0000, 32'h80FF_1234, 4'b0001, 32'h0000_0034};

    stv[0] = '{3'd0, 32'h0000_0001, 32'h0000_00AB, 4'b0010, 32'h0000_AB00};
    stv[1] = '{3'd2, 32'h0000_0008, 32'h1234_5678, 4'b1111, 32'h1234_5678};
    stv[2] = '{3'd0, 32'h0000_0007, 32'h0000_005C, 4'b1000, 32'h5C00_0000};
    stv[3] = '{3'd1, 32'h0000_0000, 32'h0000_1357, 4'b0011, 32'h0000_1357};

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_ir", wb_ir, 0);
    @(negedge clk1);
    @(negedge clk1);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      drive(vt[i].v, vt[i].ir, vt[i].res, 32'h0000_00C3, vt[i].ctrl);
      #1;
      chk($sformatf("vec%0d_stall", i), stall, 0);
      chk($sformatf("vec%0d_req", i), dmem_req, 0);
      tick;
      chk($sformatf("vec%0d_wb_valid", i), wb_valid, vt[i].e_vld);
      chk($sformatf("vec%0d_wb_err", i), wb_err, vt[i].e_err);
      chk($sformatf("vec%0d_wb_ir", i), wb_ir, vt[i].e_ir);
      chk($sformatf("vec%0d_wb_result", i), wb_result, vt[i].e_res);
      chk($sformatf("vec%0d_wb_ctrl", i), wb_ctrl, vt[i].e_ctrl);
      chk($sformatf("vec%0d_wb_ld", i), wb_load_data, 0);
      chk($sformatf("vec%0d_req_after", i), dmem_req, 0);
    end
    drive(1'b0, '0, '0, '0, '0);
    tick;

    // Loads: gnt in the first REQ cycle, rvalid the next.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, mk_ir(lt[i].f3, OPC_LD), lt[i].addr, 32'h0, 8'hC0 + 8'(i));
      #1;
      chk($sformatf("ld%0d_stall_idle", i), stall, 1);
      chk($sformatf("ld%0d_req_idle", i), dmem_req, 0);
      tick;
      chk($sformatf("ld%0d_req", i), dmem_req, 1);
      chk($sformatf("ld%0d_we", i), dmem_we, 0);
      chk($sformatf("ld%0d_addr", i), dmem_addr, {lt[i].addr[31:2], 2'b00});
      chk($sformatf("ld%0d_be", i), dmem_be, lt[i].e_be);
      dmem_gnt = 1'b1;
      #1;
      chk($sformatf("ld%0d_stall_gnt", i), stall, 1);
      tick;
      dmem_gnt = 1'b0;
      dmem_rvalid = 1'b1;
      dmem_rdata = lt[i].rdata;
      #1;
      chk($sformatf("ld%0d_req_wait", i), dmem_req, 0);
      chk($sformatf("ld%0d_wbv_wait", i), wb_valid, 0);
      chk($sformatf("ld%0d_stall_rv", i), stall, 0);
      tick;
      dmem_rvalid = 1'b0;
      dmem_rdata = 32'h5555_5555;
      ex_valid = 1'b0;
      chk($sformatf("ld%0d_wb_valid", i), wb_valid, 1);
      chk($sformatf("ld%0d_wb_ld", i), wb_load_data, lt[i].e_data);
      chk($sformatf("ld%0d_wb_err", i), wb_err, 0);
      chk($sformatf("ld%0d_wb_res", i), wb_result, lt[i].addr);
      chk($sformatf("ld%0d_wb_ctrl", i), wb_ctrl, 8'hC0 + 8'(i));
    end

    // Stores: gnt in the first REQ cycle gives 2-cycle latency.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, mk_ir(stv[i].f3, OPC_ST), stv[i].addr, stv[i].sdata, 8'hD0 + 8'(i));
      #1;
      chk($sformatf("st%0d_stall_idle", i), stall, 1);
      tick;
      chk($sformatf("st%0d_req", i), dmem_req, 1);
      chk($sformatf("st%0d_we", i), dmem_we, 1);
      chk($sformatf("st%0d_addr", i), dmem_addr, {stv[i].addr[31:2], 2'b00});
      chk($sformatf("st%0d_be", i), dmem_be, stv[i].e_be);
      chk($sformatf("st%0d_wdata", i), dmem_wdata, stv[i].e_wdata);
      dmem_gnt = 1'b1;
      #1;
      chk($sformatf("st%0d_stall_gnt", i), stall, 0);
      tick;
      dmem_gnt = 1'b0;
      ex_valid = 1'b0;
      chk($sformatf("st%0d_wb_valid", i), wb_valid, 1);
      chk($sformatf("st%0d_wb_err", i), wb_err, 0);
      chk($sformatf("st%0d_wb_ld", i), wb_load_data, 0);
      chk($sformatf("st%0d_req_done", i), dmem_req, 0);
    end

    // SH 0xBEEF at 0x202, gnt after 3 waiting REQ cycles.
    drive(1'b1, mk_ir(3'd1, OPC_ST), 32'h0000_0202, 32'h0000_BEEF, 8'hE1);
    stall_cnt = 0;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (stall) stall_cnt++;
      if (c > 0) begin
        if (wb_valid) pulses++;
        chk($sformatf("sh_req_c%0d", c), dmem_req, 1);
        chk($sformatf("sh_be_c%0d", c), dmem_be, 4'b1100);
        chk($sformatf("sh_wdata_c%0d", c), dmem_wdata, 32'hBEEF_0000);
        chk($sformatf("sh_addr_c%0d", c), dmem_addr, 32'h0000_0200);
      end
      tick;
    end
    dmem_gnt = 1'b1;
    #1;
    if (stall) stall_cnt++;
    if (wb_valid) pulses++;
    chk("sh_stall_gnt", stall, 0);
    tick;
    dmem_gnt = 1'b0;
    ex_valid = 1'b0;
    chk("sh_wb_valid", wb_valid, 1);
    chk("sh_wb_result", wb_result, 32'h0000_0202);
    chk("sh_wb_ctrl", wb_ctrl, 8'hE1);
    if (wb_valid) pulses++;
    tick;
    if (wb_valid) pulses++;
    tick;
    if (wb_valid) pulses++;
    chk("sh_stall_cycles", stall_cnt, 4);
    chk("sh_wb_pulses", pulses, 1);

    // LHU at 0x002, gnt but never rvalid: abort after 16 cycles in REQ/WAIT.
    drive(1'b1, mk_ir(3'd5, OPC_LD), 32'h0000_0002, 32'h0, 8'hF0);
    #1;
    chk("tmo_stall_idle", stall, 1);
    tick;
    done = 1'b0;
    n = 0;
    for (int c = 1; c <= 40 && !done; c++) begin
      dmem_gnt = (c == 1);
      #1;
      if (!stall) begin
        done = 1'b1;
        n = c;
      end else begin
        tick;
      end
    end
    dmem_gnt = 1'b0;
    chk("tmo_released", done, 1);
    chk("tmo_cycles", n, 16);
    tick;
    ex_valid = 1'b0;
    chk("tmo_wb_valid", wb_valid, 1);
    chk("tmo_wb_err", wb_err, 1);
    chk("tmo_wb_ld", wb_load_data, 0);
    chk("tmo_wb_ctrl", wb_ctrl, 8'hF0);
    chk("tmo_req", dmem_req, 0);
    tick;
    chk("tmo_wb_valid_after", wb_valid, 0);
    chk("tmo_stall_after", stall, 0);

    // ADD then LW 0x10 back-to-back; rvalid during REQ is ignored.
    drive(1'b1, mk_ir(3'd0, OPC_ADD), 32'h0000_0077, 32'h0, 8'h01);
    #1;
    chk("b2b_add_stall", stall, 0);
    tick;
    drive(1'b1, mk_ir(3'd2, OPC_LD), 32'h0000_0010, 32'h0, 8'h02);
    chk("b2b_add_wbv", wb_valid, 1);
    chk("b2b_add_wbir", wb_ir, mk_ir(3'd0, OPC_ADD));
    chk("b2b_add_wbres", wb_result, 32'h0000_0077);
    #1;
    chk("b2b_lw_stall", stall, 1);
    tick;
    chk("b2b_req1", dmem_req, 1);
    chk("b2b_wbv_req1", wb_valid, 0);
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'h1111_1111;
    #1;
    chk("b2b_stall_rv_in_req", stall, 1);
    tick;
    dmem_rvalid = 1'b0;
    chk("b2b_req2", dmem_req, 1);
    chk("b2b_wbv_req2", wb_valid, 0);
    dmem_gnt = 1'b1;
    tick;
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    chk("b2b_wbv_wait", wb_valid, 0);
    tick;
    dmem_rvalid = 1'b0;
    ex_valid = 1'b0;
    chk("b2b_lw_wbv", wb_valid, 1);
    chk("b2b_lw_ld", wb_load_data, 32'hDEAD_BEEF);
    chk("b2b_lw_ir", wb_ir, mk_ir(3'd2, OPC_LD));
    chk("b2b_lw_ctrl", wb_ctrl, 8'h02);

    // Reset while in WAIT, then a stale rvalid.
    drive(1'b1, mk_ir(3'd2, OPC_LD), 32'h0000_0020, 32'h0, 8'h03);
    tick;
    dmem_gnt = 1'b1;
    tick;
    dmem_gnt = 1'b0;
    #1;
    chk("rw_stall_wait", stall, 1);
    chk("rw_req_wait", dmem_req, 0);
    rst_n = 1'b0;
    ex_valid = 1'b0;
    #1;
    chk("rw_stall", stall, 0);
    chk("rw_req", dmem_req, 0);
    chk("rw_we", dmem_we, 0);
    chk("rw_addr", dmem_addr, 0);
    chk("rw_be", dmem_be, 0);
    chk("rw_wdata", dmem_wdata, 0);
    chk("rw_wb_valid", wb_valid, 0);
    chk("rw_wb_ir", wb_ir, 0);
    chk("rw_wb_result", wb_result, 0);
    chk("rw_wb_ld", wb_load_data, 0);
    chk("rw_wb_ctrl", wb_ctrl, 0);
    chk("rw_wb_err", wb_err, 0);
    tick;
    rst_n = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'hCAFE_F00D;
    tick;
    dmem_rvalid = 1'b0;
    chk("rw_late_rvalid_wbv", wb_valid, 0);
    chk("rw_late_rvalid_ld", wb_load_data, 0);
    chk("rw_late_req", dmem_req, 0);
    tick;
    chk("rw_late_wbv2", wb_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
